// File: rtl/if_fetch.sv
// if_fetch: instruction-fetch stage assembling 32-bit words from four
// little-endian byte reads and presenting them to the IF/ID register.
//
// Ports:
//   clk, rst_n        clock, async active-low reset
//   stl_mm            downstream stall (1 = IF/ID holds this edge)
//   br_en, br_target  redirect from EX (target bits [1:0] ignored)
//   mem_req/mem_addr  byte read request (combinational)
//   mem_gnt           request accepted this cycle
//   mem_rdata         read byte, one cycle after an accepted request
//   if_pc/if_is       presented PC and word (word is 0 when not valid)
//   mmif_ok           2'b01 valid word, 2'b00 bubble
//
// Optional macro IF_ICACHE_EN adds a direct-mapped word cache of
// ICACHE_ENTRIES entries; without it every fetch uses four byte reads.
module if_fetch #(
    parameter logic [31:0] RESET_PC       = 32'h0,
    parameter int          ICACHE_ENTRIES = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stl_mm,
    input  logic        br_en,
    input  logic [31:0] br_target,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic        mem_gnt,
    input  logic [7:0]  mem_rdata,
    output logic [31:0] if_pc,
    output logic [31:0] if_is,
    output logic [1:0]  mmif_ok
);

    typedef enum logic {
        FETCH,
        PRESENT
    } state_t;

    state_t      state;
    logic [31:0] fpc;
    logic [2:0]  bcnt;
    logic [2:0]  rcnt;
    logic        inflight;
    logic [31:0] wbuf;
    logic [31:0] is_q;
    logic        ok_q;

    logic        hit;
    logic [31:0] hit_word;
    logic        last;
    logic [31:0] full_word;

    // Final byte of a miss arrives this cycle; a redirect at the same
    // edge wins, so the byte is dropped.
    assign last = (state == FETCH) && inflight &&
                  (rcnt == 3'd3) && !br_en;

    assign full_word = {mem_rdata, wbuf[23:0]};

`ifdef IF_ICACHE_EN
    localparam int IW = $clog2(ICACHE_ENTRIES);
    localparam int TW = 30 - IW;

    logic [ICACHE_ENTRIES-1:0] cv;
    logic [TW-1:0]             ctag  [ICACHE_ENTRIES];
    logic [31:0]               cdata [ICACHE_ENTRIES];
    logic [IW-1:0]             idx;
    logic [TW-1:0]             tag;

    assign idx = fpc[IW+1:2];
    assign tag = fpc[31:IW+2];

    assign hit = (state == FETCH) && (bcnt == 3'd0) &&
                 cv[idx] && (ctag[idx] == tag);
    assign hit_word = cdata[idx];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cv <= '0;
        end else if (last) begin
            cv[idx] <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (last) begin
            ctag[idx]  <= tag;
            cdata[idx] <= full_word;
        end
    end
`else
    assign hit      = 1'b0;
    assign hit_word = '0;
`endif

    // Gated by rst_n so the bus is quiet while reset is asserted.
    assign mem_req = rst_n && (state == FETCH) &&
                     (bcnt < 3'd4) && !stl_mm && !hit;
    assign mem_addr = mem_req ? (fpc + {29'b0, bcnt}) : 32'h0;

    assign if_pc   = fpc;
    assign if_is   = is_q;
    assign mmif_ok = {1'b0, ok_q};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= FETCH;
            fpc      <= RESET_PC;
            bcnt     <= 3'd0;
            rcnt     <= 3'd0;
            inflight <= 1'b0;
            wbuf     <= 32'h0;
            is_q     <= 32'h0;
            ok_q     <= 1'b0;
        end else if (br_en) begin
            // Clearing inflight discards data of a request
            // accepted in this same cycle.
            state    <= FETCH;
            fpc      <= {br_target[31:2], 2'b00};
            bcnt     <= 3'd0;
            rcnt     <= 3'd0;
            inflight <= 1'b0;
            wbuf     <= 32'h0;
            is_q     <= 32'h0;
            ok_q     <= 1'b0;
        end else begin
            unique case (state)
                FETCH: begin
                    if (hit) begin
                        state <= PRESENT;
                        is_q  <= hit_word;
                        ok_q  <= 1'b1;
                    end else begin
                        if (mem_req && mem_gnt) begin
                            bcnt <= bcnt + 3'd1;
                        end
                        inflight <= mem_req && mem_gnt;
                        if (inflight) begin
                            wbuf[{rcnt[1:0], 3'b000} +: 8] <= mem_rdata;
                            rcnt <= rcnt + 3'd1;
                        end
                        if (last) begin
                            state <= PRESENT;
                            is_q  <= full_word;
                            ok_q  <= 1'b1;
                        end
                    end
                end
                PRESENT: begin
                    if (!stl_mm) begin
                        state    <= FETCH;
                        fpc      <= fpc + 32'd4;
                        bcnt     <= 3'd0;
                        rcnt     <= 3'd0;
                        inflight <= 1'b0;
                        wbuf     <= 32'h0;
                        is_q     <= 32'h0;
                        ok_q     <= 1'b0;
                    end
                end
                default: begin
                    state <= FETCH;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_if_fetch.sv
// tb_if_fetch: randomized bench for if_fetch with an in-bench
// transaction-level fetch model and a few hand-computed expectations.
module tb_if_fetch;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        stl_mm = 1'b0;
    logic        br_en = 1'b0;
    logic [31:0] br_target = 32'h0;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_gnt = 1'b0;
    logic [7:0]  mem_rdata = 8'h0;
    logic [31:0] if_pc;
    logic [31:0] if_is;
    logic [1:0]  mmif_ok;

    always #5 clk = ~clk;

    if_fetch #(.RESET_PC(32'h0), .ICACHE_ENTRIES(16)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .stl_mm(stl_mm),
        .br_en(br_en),
        .br_target(br_target),
        .mem_req(mem_req),
        .mem_addr(mem_addr),
        .mem_gnt(mem_gnt),
        .mem_rdata(mem_rdata),
        .if_pc(if_pc),
        .if_is(if_is),
        .mmif_ok(mmif_ok)
    );

    logic [7:0] mem_b [0:1023];

    int errors = 0;
    int checks = 0;

    // model: PC being fetched, whether its word is on display,
    // how many bytes were granted / returned, and one pending grant
    logic [31:0] m_pc;
    bit          m_pres;
    int          m_req_n;
    int          m_rx;
    bit          m_pend;
    logic [31:0] c_pc [16];
    bit          c_v  [16];

    bit          g_prev;
    logic [31:0] a_prev;

    function automatic logic [7:0] mb(input logic [31:0] a);
        return mem_b[int'(a & 32'h3FF)];
    endfunction

    function automatic logic [31:0] word_at(input logic [31:0] a);
        return {mb(a + 32'd3), mb(a + 32'd2), mb(a + 32'd1), mb(a)};
    endfunction

    function automatic bit m_hit();
`ifdef IF_ICACHE_EN
        int i;
        i = int'((m_pc >> 2) & 32'hF);
        return !m_pres && m_req_n == 0 && c_v[i] && c_pc[i] == m_pc;
`else
        return 1'b0;
`endif
    endfunction

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        m_pc    = 32'h0;
        m_pres  = 1'b0;
        m_req_n = 0;
        m_rx    = 0;
        m_pend  = 1'b0;
        for (int i = 0; i < 16; i++) c_v[i] = 1'b0;
        g_prev  = 1'b0;
    endtask

    task automatic step(input bit stl, input bit br, input bit gnt,
                        input logic [31:0] tgt);
        bit          h;
        bit          exp_req;
        bit          g;
        logic [31:0] a;
        int          ci;
        @(negedge clk);
        mem_rdata = g_prev ? mb(a_prev) : 8'($urandom);
        stl_mm    = stl;
        br_en     = br;
        br_target = tgt;
        mem_gnt   = gnt;
        #1;
        h       = m_hit();
        exp_req = !m_pres && m_req_n < 4 && !stl && !h;
        a       = m_pc + 32'(m_req_n);
        chk("if_pc", if_pc, m_pc);
        chk("mmif_ok", {30'b0, mmif_ok}, m_pres ? 32'd1 : 32'd0);
        chk("if_is", if_is, m_pres ? word_at(m_pc) : 32'h0);
        chk("mem_req", {31'b0, mem_req}, {31'b0, exp_req});
        if (exp_req) chk("mem_addr", mem_addr, a);
        g      = exp_req && gnt;
        g_prev = g;
        a_prev = a;
        if (br) begin
            m_pc    = {tgt[31:2], 2'b00};
            m_pres  = 1'b0;
            m_req_n = 0;
            m_rx    = 0;
            m_pend  = 1'b0;
            g_prev  = 1'b0;
        end else if (m_pres) begin
            if (!stl) begin
                m_pc    = m_pc + 32'd4;
                m_pres  = 1'b0;
                m_req_n = 0;
                m_rx    = 0;
                m_pend  = 1'b0;
            end
        end else if (h) begin
            m_pres = 1'b1;
        end else begin
            if (m_pend) m_rx++;
            m_pend = g;
            if (g) m_req_n++;
            if (m_rx == 4) begin
                m_pres = 1'b1;
                ci = int'((m_pc >> 2) & 32'hF);
                c_pc[ci] = m_pc;
                c_v[ci]  = 1'b1;
            end
        end
    endtask

    task automatic reset_now();
        rst_n = 1'b0;
        #1;
        chk("rst mem_req", {31'b0, mem_req}, 32'd0);
        chk("rst mem_addr", mem_addr, 32'h0);
        chk("rst if_pc", if_pc, 32'h0);
        chk("rst if_is", if_is, 32'h0);
        chk("rst mmif_ok", {30'b0, mmif_ok}, 32'd0);
        model_reset();
        @(posedge clk);
        #2;
        rst_n = 1'b1;
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) mem_b[i] = 8'($urandom);
        mem_b[0] = 8'h13;
        mem_b[1] = 8'h00;
        mem_b[2] = 8'h00;
        mem_b[3] = 8'h00;
        model_reset();
        #12;
        reset_now();

        // miss latency and stall during PRESENT
        for (int s = 0; s < 10; s++) begin
            step(s >= 5 && s <= 7, 1'b0, 1'b1, 32'h0);
            if (s == 0) chk("lit addr c0", mem_addr, 32'h0);
            if (s == 3) chk("lit addr c3", mem_addr, 32'h3);
            if (s == 5) chk("lit word c5", if_is, 32'h00000013);
            if (s == 5) chk("lit ok c5", {30'b0, mmif_ok}, 32'd1);
            if (s == 6) chk("lit req stl", {31'b0, mem_req}, 32'd0);
            if (s == 7) chk("lit pc hold", if_pc, 32'h0);
            if (s == 9) chk("lit addr next", mem_addr, 32'h4);
        end

        // redirect to 0x103 while a byte is in flight
        step(1'b0, 1'b1, 1'b1, 32'h103);
        step(1'b0, 1'b0, 1'b1, 32'h0);
        chk("lit br addr", mem_addr, 32'h100);
        step(1'b0, 1'b0, 1'b1, 32'h0);
        reset_now();

        // grant withheld on byte 2
        for (int s = 0; s < 8; s++) begin
            step(1'b0, 1'b0, !(s == 2 || s == 3), 32'h0);
            if (s >= 2 && s <= 4) chk("lit addr held", mem_addr, 32'h2);
            if (s == 7) chk("lit ok late", {30'b0, mmif_ok}, 32'd1);
            if (s == 7) chk("lit word late", if_is, 32'h00000013);
        end

`ifdef IF_ICACHE_EN
        step(1'b0, 1'b1, 1'b1, 32'h0);
        step(1'b0, 1'b0, 1'b1, 32'h0);
        chk("lit hit noreq", {31'b0, mem_req}, 32'd0);
        step(1'b0, 1'b0, 1'b1, 32'h0);
        chk("lit hit ok", {30'b0, mmif_ok}, 32'd1);
`endif

        for (int n = 0; n < 4000; n++) begin
            step($urandom_range(0, 4) == 0,
                 $urandom_range(0, 29) == 0,
                 $urandom_range(0, 3) != 0,
                 $urandom & 32'h3FF);
            if ($urandom_range(0, 299) == 0) reset_now();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
